qsys_system_onchip_mem_tester: RTL and testbench

//  Avalon-MM master that drives the on-chip RAM slave (s1): fills a window with a

---
 rtl/qsys_system_onchip_mem_tester.sv | 195 +++++++++++++++++++
 tb/tb_qsys_system_onchip_mem_tester.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/qsys_system_onchip_mem_tester.sv
// Avalon-MM RAM self-test master: writes a seeded incrementing pattern over a
// wrapping address window, reads it back and reports mismatches.
//
//  state   | meaning
//  S_IDLE  | waiting for start; status outputs hold the last result
//  S_WRITE | one pattern write per cycle over the window
//  S_READ  | one read per cycle over the window; expected data enters the pipe
//  S_DRAIN | READ_LATENCY cycles so the last reads can be compared
//  S_DONE  | single-cycle done pulse; pass is resolved here
module qsys_system_onchip_mem_tester #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 25000,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   num_words,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    output logic                m_reset_req,
    input  logic [DATA_W-1:0]   m_readdata
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   n_q, n_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic                pass_q, pass_d;
    logic [15:0]         err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;

    // Expected-read pipeline; stage READ_LATENCY-1 lines up with m_readdata.
    logic [DATA_W-1:0]   exp_data_q [READ_LATENCY];
    logic [DATA_W-1:0]   exp_data_d [READ_LATENCY];
    logic [ADDR_W-1:0]   exp_addr_q [READ_LATENCY];
    logic [ADDR_W-1:0]   exp_addr_d [READ_LATENCY];
    logic                exp_vld_q  [READ_LATENCY];
    logic                exp_vld_d  [READ_LATENCY];

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] nxt;
        nxt = (ADDR_W+1)'(a) + (ADDR_W+1)'(1);
        if (nxt >= (ADDR_W+1)'(DEPTH)) return '0;
        return nxt[ADDR_W-1:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        pat_d        = pat_q;
        base_d       = base_q;
        n_d          = n_q;
        seed_d       = seed_q;
        pass_d       = pass_q;
        err_d        = err_q;
        first_d      = first_q;
        m_chipselect = 1'b0;
        m_write      = 1'b0;

        for (int i = READ_LATENCY - 1; i > 0; i--) begin
            exp_data_d[i] = exp_data_q[i-1];
            exp_addr_d[i] = exp_addr_q[i-1];
            exp_vld_d[i]  = exp_vld_q[i-1];
        end
        exp_data_d[0] = pat_q;
        exp_addr_d[0] = addr_q;
        exp_vld_d[0]  = 1'b0;

        if (exp_vld_q[READ_LATENCY-1] && (m_readdata != exp_data_q[READ_LATENCY-1])) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    first_d = exp_addr_q[READ_LATENCY-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    n_d     = num_words;
                    seed_d  = seed;
                    addr_d  = base_addr;
                    pat_d   = seed;
                    idx_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    pass_d  = 1'b0;
                    state_d = (num_words == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                if (idx_q == n_q - ADDR_W'(1)) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    addr_d  = base_q;
                    pat_d   = seed_q;
                end else begin
                    idx_d  = idx_q + ADDR_W'(1);
                    addr_d = wrap_inc(addr_q);
                    pat_d  = pat_q + DATA_W'(1);
                end
            end
            S_READ: begin
                m_chipselect = 1'b1;
                exp_vld_d[0] = 1'b1;
                if (idx_q == n_q - ADDR_W'(1)) begin
                    state_d = S_DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d  = idx_q + ADDR_W'(1);
                    addr_d = wrap_inc(addr_q);
                    pat_d  = pat_q + DATA_W'(1);
                end
            end
            S_DRAIN: begin
                if (idx_q == ADDR_W'(READ_LATENCY - 1)) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                pass_d  = (err_q == 16'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            pat_q   <= '0;
            base_q  <= '0;
            n_q     <= '0;
            seed_q  <= '0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                exp_data_q[i] <= '0;
                exp_addr_q[i] <= '0;
                exp_vld_q[i]  <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            pat_q      <= pat_d;
            base_q     <= base_d;
            n_q        <= n_d;
            seed_q     <= seed_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            first_q    <= first_d;
            exp_data_q <= exp_data_d;
            exp_addr_q <= exp_addr_d;
            exp_vld_q  <= exp_vld_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign m_address      = addr_q;
    assign m_writedata    = pat_q;
    assign m_byteenable   = '1;
    assign m_clken        = 1'b1;
    assign m_reset_req    = 1'b0;

endmodule

// File: tb/tb_qsys_system_onchip_mem_tester.sv
// Directed bench for the RAM tester against a behavioural 1-cycle-latency RAM
// with an optional single-address read corruption.
module tb_qsys_system_onchip_mem_tester;

    localparam int DEPTH = 25000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] base_addr;
    logic [14:0] num_words;
    logic [31:0] seed;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [14:0] first_err_addr;
    logic [14:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect, m_write, m_clken, m_reset_req;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = '0;

    logic [31:0] mem [DEPTH];
    logic        corrupt_en = 1'b0;
    logic [14:0] corrupt_addr = '0;

    int n_checks = 0;
    int n_errors = 0;

    qsys_system_onchip_mem_tester dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_words(num_words), .seed(seed), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
        .m_address(m_address), .m_byteenable(m_byteenable),
        .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_clken(m_clken),
        .m_reset_req(m_reset_req), .m_readdata(m_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_chipselect && (int'(m_address) < DEPTH)) begin
            if (m_write)
                mem[m_address] <= m_writedata;
            else
                m_readdata <= mem[m_address] ^
                              ((corrupt_en && m_address == corrupt_addr) ? 32'h0000_0100 : 32'h0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts a run and checks every cycle of the bus schedule plus the final status.
    task automatic run_test(input string name, input int base, input int n, input logic [31:0] sd,
                            input bit glitch, input bit exp_pass, input int exp_err,
                            input int exp_first);
        int total, a, i;
        logic exp_cs, exp_wr;
        @(negedge clk);
        base_addr = 15'(base); num_words = 15'(n); seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total = 2 * n + 2;
        for (int c = 1; c <= total; c++) begin
            exp_cs = (c <= 2 * n);
            exp_wr = (c <= n);
            i = (c <= n) ? c - 1 : c - n - 1;
            a = base + i;
            if (a >= DEPTH) a = a - DEPTH;
            chk({name, " cs"}, 32'(m_chipselect), 32'(exp_cs));
            chk({name, " wr"}, 32'(m_write), 32'(exp_wr));
            chk({name, " done"}, 32'(done), 32'(c == total));
            chk({name, " busy"}, 32'(busy), 32'd1);
            if (exp_cs) chk({name, " addr"}, 32'(m_address), 32'(a));
            if (exp_wr) chk({name, " wdata"}, m_writedata, sd + 32'(i));
            if (c == 1) begin
                chk({name, " pass cleared"}, 32'(pass), 32'd0);
                chk({name, " err cleared"}, 32'(err_count), 32'd0);
            end
            start = 1'b0;
            if (glitch && (c == 2 || c == n + 2)) begin
                start = 1'b1; base_addr = 15'd100; num_words = 15'd1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, " busy after"}, 32'(busy), 32'd0);
        chk({name, " done after"}, 32'(done), 32'd0);
        chk({name, " cs after"}, 32'(m_chipselect), 32'd0);
        chk({name, " pass"}, 32'(pass), 32'(exp_pass));
        chk({name, " err_count"}, 32'(err_count), 32'(exp_err));
        chk({name, " first_err_addr"}, 32'(first_err_addr), 32'(exp_first));
        @(negedge clk);
        chk({name, " done single"}, 32'(done), 32'd0);
        chk({name, " pass held"}, 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; seed = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst pass", 32'(pass), 32'd0);
        chk("rst err", 32'(err_count), 32'd0);
        chk("rst first", 32'(first_err_addr), 32'd0);
        chk("rst cs", 32'(m_chipselect), 32'd0);
        chk("rst wr", 32'(m_write), 32'd0);
        chk("rst addr", 32'(m_address), 32'd0);
        chk("rst wdata", m_writedata, 32'd0);
        chk("byteenable", 32'(m_byteenable), 32'hF);
        chk("clken", 32'(m_clken), 32'd1);
        chk("reset_req", 32'(m_reset_req), 32'd0);
        reset = 1'b0;

        run_test("t1", 0, 4, 32'hA5A5_0000, 1'b0, 1'b1, 0, 0);

        corrupt_en = 1'b1; corrupt_addr = 15'd2;
        run_test("t2", 0, 4, 32'hA5A5_0000, 1'b0, 1'b0, 1, 2);
        corrupt_en = 1'b0;

        run_test("t3", 24998, 4, 32'h1234_5678, 1'b0, 1'b1, 0, 0);
        chk("t3 mem 24999", mem[24999], 32'h1234_5679);
        chk("t3 mem 1", mem[1], 32'h1234_567B);

        // Zero-length run: done the cycle after start, no bus activity.
        @(negedge clk);
        num_words = '0; base_addr = 15'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t4 done", 32'(done), 32'd1);
        chk("t4 busy", 32'(busy), 32'd1);
        chk("t4 cs", 32'(m_chipselect), 32'd0);
        @(negedge clk);
        chk("t4 done drop", 32'(done), 32'd0);
        chk("t4 busy drop", 32'(busy), 32'd0);
        chk("t4 cs idle", 32'(m_chipselect), 32'd0);
        chk("t4 pass", 32'(pass), 32'd1);
        chk("t4 err", 32'(err_count), 32'd0);

        run_test("t5 glitch", 10, 4, 32'h0000_0040, 1'b1, 1'b1, 0, 0);

        // Reset in the middle of the read phase.
        @(negedge clk);
        base_addr = 15'd20; num_words = 15'd4; seed = 32'hDEAD_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5 mid read cs", 32'(m_chipselect), 32'd1);
        chk("t5 mid read wr", 32'(m_write), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5 rst cs", 32'(m_chipselect), 32'd0);
        chk("t5 rst busy", 32'(busy), 32'd0);
        chk("t5 rst pass", 32'(pass), 32'd0);
        chk("t5 rst err", 32'(err_count), 32'd0);
        chk("t5 rst first", 32'(first_err_addr), 32'd0);
        chk("t5 rst addr", 32'(m_address), 32'd0);
        chk("t5 rst wdata", m_writedata, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5 no done", 32'(done), 32'd0);

        run_test("t6", 300, 3, 32'hFFFF_FFFE, 1'b0, 1'b1, 0, 0);
        chk("t6 mem 302", mem[302], 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
